// File: rtl/irq_controller.sv
// Fixed-priority interrupt sequencer: 6502-style entry (vector fetch, push PC/P) and RTI return.
// Optional macro IRQ_NEST_EN enables an in-service priority stack of NEST_DEPTH levels.
module irq_controller #(
    parameter int                 NUM_SRC    = 4,
    parameter logic [15:0]        VEC_BASE   = 16'hFFF8,
    parameter logic [NUM_SRC-1:0] NMI_MASK   = 4'b0001,
    parameter logic [NUM_SRC-1:0] LEVEL_MASK = 4'b1000,
    parameter logic [7:0]         STACK_PAGE = 8'h01,
    parameter int                 NEST_DEPTH = 2,
    localparam int                SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               start,
    input  logic               is_rti,
    input  logic [15:0]        pc_in,
    input  logic [7:0]         status_in,
    input  logic [7:0]         sp_in,
    output logic [15:0]        mem_addr,
    input  logic [7:0]         mem_rdata,
    output logic [7:0]         mem_wdata,
    output logic               mem_we,
    output logic [15:0]        pc_out,
    output logic [7:0]         status_out,
    output logic [7:0]         sp_out,
    output logic               done,
    output logic               busy,
    output logic [SRC_W-1:0]   active_src,
    output logic               in_service
);

    typedef enum logic [3:0] {
        IDLE, VEC_LO, VEC_HI, PUSH_PCH, PUSH_PCL, PUSH_P,
        POP_P, POP_PCL, POP_PCH, POP_WAIT, DONE
    } state_t;

    state_t             state_r, next_state_s;
    logic [NUM_SRC-1:0] irq_prev_r, latch_r, rise_s, clr_s;
    logic [NUM_SRC-1:0] pending_s, allow_s, eligible_s;
    logic [SRC_W-1:0]   winner_s, src_sel_s, active_src_r;
    logic [15:0]        vec_addr_s, addr_nx_s, mem_addr_r, pc_out_r;
    logic [7:0]         wdata_nx_s, mem_wdata_r, status_out_r, sp_out_r;
    logic               we_nx_s, mem_we_r, done_r, busy_r, in_service_r, svc_after_pop_s;
    logic [7:0]         vec_lo_r, vec_hi_r, pop_p_r, pop_pcl_r, pop_pch_r;
    logic               pop_wait_r;

    function automatic logic [SRC_W-1:0] first_set(input logic [NUM_SRC-1:0] v);
        first_set = {SRC_W{1'b0}};
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) first_set = SRC_W'(i);
        end
    endfunction

    assign rise_s     = irq_src & ~irq_prev_r & ~LEVEL_MASK;
    assign pending_s  = (latch_r & ~LEVEL_MASK) | (irq_src & LEVEL_MASK);
    assign eligible_s = pending_s & (NMI_MASK | {NUM_SRC{~status_in[2]}}) & allow_s;
    assign winner_s   = first_set(eligible_s);
    assign src_sel_s  = (state_r == IDLE) ? winner_s : active_src_r;
    assign vec_addr_s = VEC_BASE + {{(15-SRC_W){1'b0}}, src_sel_s, 1'b0};

`ifdef IRQ_NEST_EN
    localparam int CNT_W = $clog2(NEST_DEPTH + 1);

    logic [SRC_W-1:0] nest_stack_r [NEST_DEPTH];
    logic [CNT_W-1:0] nest_cnt_r;
    logic [SRC_W-1:0] nest_top_s;
    logic             nest_full_s;

    // Top-of-stack lookup and preemption filter: only strictly higher priority may enter
    always_comb begin
        nest_top_s = {SRC_W{1'b0}};
        allow_s    = {NUM_SRC{1'b0}};
        for (int k = 0; k < NEST_DEPTH; k++) begin
            if (CNT_W'(k + 1) == nest_cnt_r) nest_top_s = nest_stack_r[k];
            else nest_top_s = nest_top_s;
        end
        nest_full_s = (nest_cnt_r == CNT_W'(NEST_DEPTH));
        for (int i = 0; i < NUM_SRC; i++) begin
            allow_s[i] = (nest_cnt_r == {CNT_W{1'b0}}) ||
                         (!nest_full_s && (SRC_W'(i) < nest_top_s));
        end
        svc_after_pop_s = (nest_cnt_r > CNT_W'(1));
    end

    // Push the serviced source on entry completion, pop one level on return completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nest_cnt_r <= {CNT_W{1'b0}};
            for (int k = 0; k < NEST_DEPTH; k++) nest_stack_r[k] <= {SRC_W{1'b0}};
        end else if (!halt && next_state_s == DONE) begin
            if (state_r == PUSH_P) begin
                for (int k = 0; k < NEST_DEPTH; k++) begin
                    if (CNT_W'(k) == nest_cnt_r) nest_stack_r[k] <= active_src_r;
                end
                nest_cnt_r <= nest_cnt_r + CNT_W'(1);
            end else if (state_r == POP_WAIT) begin
                nest_cnt_r <= nest_cnt_r - CNT_W'(1);
            end
        end
    end
`else
    assign allow_s         = {NUM_SRC{~in_service_r}};
    assign svc_after_pop_s = 1'b0;
`endif

    // Next-state and next bus cycle; bus outputs are registered from the state being entered
    always_comb begin
        next_state_s = state_r;
        addr_nx_s    = 16'h0000;
        wdata_nx_s   = 8'h00;
        we_nx_s      = 1'b0;
        if (halt) begin
            next_state_s = state_r;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!start)                      next_state_s = IDLE;
                    else if (is_rti && in_service_r) next_state_s = POP_P;
                    else if (|eligible_s)            next_state_s = VEC_LO;
                    else                             next_state_s = DONE;
                end
                VEC_LO:   next_state_s = VEC_HI;
                VEC_HI:   next_state_s = PUSH_PCH;
                PUSH_PCH: next_state_s = PUSH_PCL;
                PUSH_PCL: next_state_s = PUSH_P;
                PUSH_P:   next_state_s = DONE;
                POP_P:    next_state_s = POP_PCL;
                POP_PCL:  next_state_s = POP_PCH;
                POP_PCH:  next_state_s = POP_WAIT;
                // Two cycles here: the last read returns in the first, the second aligns return with entry
                POP_WAIT: next_state_s = pop_wait_r ? DONE : POP_WAIT;
                DONE:     next_state_s = IDLE;
                default:  next_state_s = IDLE;
            endcase
        end
        case (next_state_s)
            VEC_LO:   addr_nx_s = vec_addr_s;
            VEC_HI:   addr_nx_s = vec_addr_s + 16'd1;
            PUSH_PCH: begin addr_nx_s = {STACK_PAGE, sp_in};         wdata_nx_s = pc_in[15:8]; we_nx_s = 1'b1; end
            PUSH_PCL: begin addr_nx_s = {STACK_PAGE, sp_in - 8'd1}; wdata_nx_s = pc_in[7:0];  we_nx_s = 1'b1; end
            PUSH_P:   begin addr_nx_s = {STACK_PAGE, sp_in - 8'd2}; wdata_nx_s = status_in;   we_nx_s = 1'b1; end
            POP_P:    addr_nx_s = {STACK_PAGE, sp_in + 8'd1};
            POP_PCL:  addr_nx_s = {STACK_PAGE, sp_in + 8'd2};
            POP_PCH:  addr_nx_s = {STACK_PAGE, sp_in + 8'd3};
            default:  addr_nx_s = 16'h0000;
        endcase
    end

    // Source latches keep capturing while halted; set beats the clear issued on entering VEC_LO
    always_comb begin
        clr_s = {NUM_SRC{1'b0}};
        if (state_r == IDLE && next_state_s == VEC_LO) clr_s = {{(NUM_SRC-1){1'b0}}, 1'b1} << winner_s;
        else clr_s = {NUM_SRC{1'b0}};
    end

    // Edge detector and pending latches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_prev_r <= {NUM_SRC{1'b0}};
            latch_r    <= {NUM_SRC{1'b0}};
        end else begin
            irq_prev_r <= irq_src;
            latch_r    <= (latch_r & ~clr_s) | rise_s;
        end
    end

    // Sequencer state, bus registers, read-data captures and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            mem_addr_r   <= 16'h0000;
            mem_wdata_r  <= 8'h00;
            mem_we_r     <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
            active_src_r <= {SRC_W{1'b0}};
            in_service_r <= 1'b0;
            pc_out_r     <= 16'h0000;
            status_out_r <= 8'h00;
            sp_out_r     <= 8'h00;
            vec_lo_r     <= 8'h00;
            vec_hi_r     <= 8'h00;
            pop_p_r      <= 8'h00;
            pop_pcl_r    <= 8'h00;
            pop_pch_r    <= 8'h00;
            pop_wait_r   <= 1'b0;
        end else if (!halt) begin
            state_r     <= next_state_s;
            mem_addr_r  <= addr_nx_s;
            mem_wdata_r <= wdata_nx_s;
            mem_we_r    <= we_nx_s;
            done_r      <= (next_state_s == DONE);
            busy_r      <= (next_state_s != IDLE);
            if (state_r == IDLE && next_state_s == VEC_LO) active_src_r <= winner_s;
            case (state_r)
                VEC_HI:   vec_lo_r  <= mem_rdata;
                PUSH_PCH: vec_hi_r  <= mem_rdata;
                POP_PCL:  pop_p_r   <= mem_rdata;
                POP_PCH:  pop_pcl_r <= mem_rdata;
                POP_WAIT: begin
                    if (!pop_wait_r) pop_pch_r <= mem_rdata;
                    pop_wait_r <= ~pop_wait_r;
                end
                default: pop_wait_r <= 1'b0;
            endcase
            if (next_state_s == DONE) begin
                case (state_r)
                    IDLE: begin
                        pc_out_r     <= pc_in;
                        status_out_r <= status_in;
                        sp_out_r     <= sp_in;
                    end
                    PUSH_P: begin
                        pc_out_r     <= {vec_hi_r, vec_lo_r};
                        status_out_r <= status_in | 8'h04;
                        sp_out_r     <= sp_in - 8'd3;
                        in_service_r <= 1'b1;
                    end
                    POP_WAIT: begin
                        pc_out_r     <= {pop_pch_r, pop_pcl_r};
                        status_out_r <= pop_p_r;
                        sp_out_r     <= sp_in + 8'd3;
                        in_service_r <= svc_after_pop_s;
                    end
                    default: in_service_r <= in_service_r;
                endcase
            end
        end
    end

    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_we     = mem_we_r;
    assign pc_out     = pc_out_r;
    assign status_out = status_out_r;
    assign sp_out     = sp_out_r;
    assign done       = done_r;
    assign busy       = busy_r;
    assign active_src = active_src_r;
    assign in_service = in_service_r;

endmodule
